// File: rtl/gci_std_display_special_arbiter.sv
// Two-port (host / display engine) arbiter and 3-state sequencer in front of the
// 256 x 32-bit display special-address memory, with write protection of descriptor words.
module gci_std_display_special_arbiter #(
    parameter bit         FIXED_PRIORITY = 1'b0,
    parameter logic [7:0] PROTECT_LIMIT  = 8'h02
) (
    input  logic        iCLOCK,
    input  logic        iRESET_SYNC,
    input  logic        iHOST_REQ,
    input  logic        iHOST_RW,
    input  logic [7:0]  iHOST_ADDR,
    input  logic [31:0] iHOST_DATA,
    output logic        oHOST_BUSY,
    output logic        oHOST_VALID,
    output logic [31:0] oHOST_DATA,
    input  logic        iDISP_REQ,
    input  logic        iDISP_RW,
    input  logic [7:0]  iDISP_ADDR,
    input  logic [31:0] iDISP_DATA,
    output logic        oDISP_BUSY,
    output logic        oDISP_VALID,
    output logic [31:0] oDISP_DATA,
    output logic        oSPECIAL_REQ,
    output logic        oSPECIAL_RW,
    output logic [7:0]  oSPECIAL_ADDR,
    output logic [31:0] oSPECIAL_DATA,
    input  logic [31:0] iSPECIAL_DATA,
    output logic        oPROTECT_HIT
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state;
    logic [1:0]  req;
    logic [1:0]  req_rw;
    logic [7:0]  req_addr [2];
    logic [31:0] req_data [2];
    logic [1:0]  buf_valid;
    logic [1:0]  buf_rw;
    logic [7:0]  buf_addr [2];
    logic [31:0] buf_data [2];
    logic        grant;
    logic        last_grant;
    logic        pick;
    logic        pick_protected;
    logic [31:0] resp_word;

    // Index 0 is the host port, index 1 the display engine.
    assign req         = {iDISP_REQ, iHOST_REQ};
    assign req_rw      = {iDISP_RW, iHOST_RW};
    assign req_addr[0] = iHOST_ADDR;
    assign req_addr[1] = iDISP_ADDR;
    assign req_data[0] = iHOST_DATA;
    assign req_data[1] = iDISP_DATA;

    assign oHOST_BUSY = buf_valid[0];
    assign oDISP_BUSY = buf_valid[1];

    // On a tie, round-robin hands the grant to the port not served last.
    always_comb begin
        pick = buf_valid[0] ? 1'b0 : 1'b1;
        if (&buf_valid) begin
            pick = FIXED_PRIORITY ? 1'b0 : ~last_grant;
        end
    end

    assign pick_protected = buf_rw[pick] && (buf_addr[pick] < PROTECT_LIMIT);
    assign resp_word      = oSPECIAL_RW ? 32'h0 : iSPECIAL_DATA;

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            buf_valid <= 2'b00;
            buf_rw    <= 2'b00;
            for (int p = 0; p < 2; p++) begin
                buf_addr[p] <= 8'h00;
                buf_data[p] <= 32'h0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (req[p] && !buf_valid[p]) begin
                    buf_valid[p] <= 1'b1;
                    buf_rw[p]    <= req_rw[p];
                    buf_addr[p]  <= req_addr[p];
                    buf_data[p]  <= req_data[p];
                end
            end
            if (state == RESP) begin
                buf_valid[grant] <= 1'b0;
            end
        end
    end

    // The memory-side outputs double as the access registers: they are only
    // non-zero during ACCESS, which is exactly when the response is captured.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            state         <= IDLE;
            grant         <= 1'b0;
            last_grant    <= 1'b1;
            oSPECIAL_REQ  <= 1'b0;
            oSPECIAL_RW   <= 1'b0;
            oSPECIAL_ADDR <= 8'h00;
            oSPECIAL_DATA <= 32'h0;
            oPROTECT_HIT  <= 1'b0;
            oHOST_VALID   <= 1'b0;
            oHOST_DATA    <= 32'h0;
            oDISP_VALID   <= 1'b0;
            oDISP_DATA    <= 32'h0;
        end else begin
            oSPECIAL_REQ  <= 1'b0;
            oSPECIAL_RW   <= 1'b0;
            oSPECIAL_ADDR <= 8'h00;
            oSPECIAL_DATA <= 32'h0;
            oPROTECT_HIT  <= 1'b0;
            oHOST_VALID   <= 1'b0;
            oDISP_VALID   <= 1'b0;
            case (state)
                IDLE: begin
                    if (|buf_valid) begin
                        grant         <= pick;
                        oSPECIAL_REQ  <= !pick_protected;
                        oSPECIAL_RW   <= buf_rw[pick];
                        oSPECIAL_ADDR <= buf_addr[pick];
                        oSPECIAL_DATA <= buf_data[pick];
                        oPROTECT_HIT  <= pick_protected;
                        state         <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (grant == 1'b0) begin
                        oHOST_VALID <= 1'b1;
                        oHOST_DATA  <= resp_word;
                    end else begin
                        oDISP_VALID <= 1'b1;
                        oDISP_DATA  <= resp_word;
                    end
                    state <= RESP;
                end
                RESP: begin
                    last_grant <= grant;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gci_std_display_special_arbiter.sv
// Bench for gci_std_display_special_arbiter: a round-robin and a fixed-priority instance,
// each with its own memory, driven by shared stimulus and checked against a transaction model.
`timescale 1ns/1ps
module tb_gci_std_display_special_arbiter;

    logic        iCLOCK = 1'b0;
    logic        iRESET_SYNC;
    logic        host_req, host_rw, disp_req, disp_rw;
    logic [7:0]  host_addr, disp_addr;
    logic [31:0] host_wdata, disp_wdata;

    logic [1:0]        host_busy, host_valid, disp_busy, disp_valid;
    logic [1:0]        sp_req, sp_rw, prot;
    logic [1:0][7:0]   sp_addr;
    logic [1:0][31:0]  sp_wdata, sp_rdata, host_rdata, disp_rdata;
    logic [1:0][110:0] obs;

    logic        mem_load;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;

    logic [31:0] ref_mem [2][256];
    int checks;
    int errors;

    always #5 iCLOCK = ~iCLOCK;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        logic [31:0] mem [256];

        gci_std_display_special_arbiter #(
            .FIXED_PRIORITY(k == 1),
            .PROTECT_LIMIT (8'h02)
        ) dut (
            .iCLOCK       (iCLOCK),
            .iRESET_SYNC  (iRESET_SYNC),
            .iHOST_REQ    (host_req),
            .iHOST_RW     (host_rw),
            .iHOST_ADDR   (host_addr),
            .iHOST_DATA   (host_wdata),
            .oHOST_BUSY   (host_busy[k]),
            .oHOST_VALID  (host_valid[k]),
            .oHOST_DATA   (host_rdata[k]),
            .iDISP_REQ    (disp_req),
            .iDISP_RW     (disp_rw),
            .iDISP_ADDR   (disp_addr),
            .iDISP_DATA   (disp_wdata),
            .oDISP_BUSY   (disp_busy[k]),
            .oDISP_VALID  (disp_valid[k]),
            .oDISP_DATA   (disp_rdata[k]),
            .oSPECIAL_REQ (sp_req[k]),
            .oSPECIAL_RW  (sp_rw[k]),
            .oSPECIAL_ADDR(sp_addr[k]),
            .oSPECIAL_DATA(sp_wdata[k]),
            .iSPECIAL_DATA(sp_rdata[k]),
            .oPROTECT_HIT (prot[k])
        );

        always @(posedge iCLOCK) begin
            if (mem_load) mem[mem_addr] <= mem_wdata;
            else if (sp_req[k] && sp_rw[k]) mem[sp_addr[k]] <= sp_wdata[k];
        end

        assign sp_rdata[k] = mem[sp_addr[k]];
        assign obs[k] = {host_busy[k], host_valid[k], disp_busy[k], disp_valid[k],
                         sp_req[k], sp_rw[k], prot[k], sp_addr[k], sp_wdata[k],
                         host_rdata[k], disp_rdata[k]};
    end

    task automatic step();
        @(posedge iCLOCK);
        #1;
    endtask

    task automatic idle_inputs();
        host_req = 1'b0; host_rw = 1'b0; host_addr = 8'h00; host_wdata = 32'h0;
        disp_req = 1'b0; disp_rw = 1'b0; disp_addr = 8'h00; disp_wdata = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        iRESET_SYNC = 1'b1;
        step();
        step();
        iRESET_SYNC = 1'b0;
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        mem_load = 1'b1; mem_addr = a; mem_wdata = d;
        ref_mem[0][a] = d; ref_mem[1][a] = d;
        step();
        mem_load = 1'b0;
    endtask

    task automatic host_read_start(input logic [7:0] a);
        host_req = 1'b1; host_rw = 1'b0; host_addr = a; host_wdata = 32'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        iRESET_SYNC = 1'b1;
        step();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== '0) begin
                errors++;
                $display("[TB] FAIL reset_outputs inst%0d: got %h expected 0", k, obs[k]);
            end
        end
        iRESET_SYNC = 1'b0;
        step();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== '0) begin
                errors++;
                $display("[TB] FAIL post_reset_idle inst%0d: got %h expected 0", k, obs[k]);
            end
        end
    endtask

    task automatic test_host_read();
        preload(8'h00, 32'h0000_1000);
        host_read_start(8'h00);
        step();
        idle_inputs();
        checks++;
        if (host_busy[0] !== 1'b1) begin
            errors++; $display("[TB] FAIL read_busy_c1: got %b expected 1", host_busy[0]);
        end
        step();
        checks++;
        if ({sp_req[0], sp_rw[0], sp_addr[0]} !== {1'b1, 1'b0, 8'h00}) begin
            errors++; $display("[TB] FAIL read_access_c2: got req/rw/addr %b/%b/%h expected 1/0/00", sp_req[0], sp_rw[0], sp_addr[0]);
        end
        step();
        checks++;
        if ({host_valid[0], host_rdata[0], disp_valid[0]} !== {1'b1, 32'h0000_1000, 1'b0}) begin
            errors++; $display("[TB] FAIL read_valid_c3: got valid %b data %h expected 1 00001000", host_valid[0], host_rdata[0]);
        end
        step();
        checks++;
        if ({host_busy[0], host_valid[0]} !== 2'b00) begin
            errors++; $display("[TB] FAIL read_done_c4: got busy/valid %b/%b expected 0/0", host_busy[0], host_valid[0]);
        end
    endtask

    task automatic test_host_write();
        host_req = 1'b1; host_rw = 1'b1; host_addr = 8'h10; host_wdata = 32'hDEAD_BEEF;
        step();
        idle_inputs();
        step();
        checks++;
        if ({sp_req[0], sp_rw[0], sp_addr[0], sp_wdata[0], prot[0]} !== {1'b1, 1'b1, 8'h10, 32'hDEAD_BEEF, 1'b0}) begin
            errors++; $display("[TB] FAIL write_access_c2: got %b/%b/%h/%h prot %b expected 1/1/10/deadbeef prot 0", sp_req[0], sp_rw[0], sp_addr[0], sp_wdata[0], prot[0]);
        end
        step();
        checks++;
        if ({host_valid[0], host_rdata[0]} !== {1'b1, 32'h0}) begin
            errors++; $display("[TB] FAIL write_valid_c3: got valid %b data %h expected 1 00000000", host_valid[0], host_rdata[0]);
        end
        step();
        host_read_start(8'h10);
        step();
        idle_inputs();
        step();
        step();
        checks++;
        if ({host_valid[0], host_rdata[0]} !== {1'b1, 32'hDEAD_BEEF}) begin
            errors++; $display("[TB] FAIL write_readback: got valid %b data %h expected 1 deadbeef", host_valid[0], host_rdata[0]);
        end
        step();
    endtask

    task automatic test_protect();
        host_req = 1'b1; host_rw = 1'b1; host_addr = 8'h01; host_wdata = 32'h1234_5678;
        step();
        idle_inputs();
        step();
        checks++;
        if ({sp_req[0], prot[0], sp_rw[0], sp_addr[0]} !== {1'b0, 1'b1, 1'b1, 8'h01}) begin
            errors++; $display("[TB] FAIL protect_c2: got req %b hit %b rw %b addr %h expected 0 1 1 01", sp_req[0], prot[0], sp_rw[0], sp_addr[0]);
        end
        step();
        checks++;
        if ({host_valid[0], host_rdata[0], prot[0]} !== {1'b1, 32'h0, 1'b0}) begin
            errors++; $display("[TB] FAIL protect_valid_c3: got valid %b data %h hit %b expected 1 0 0", host_valid[0], host_rdata[0], prot[0]);
        end
        step();
        host_read_start(8'h01);
        step();
        idle_inputs();
        step();
        step();
        checks++;
        if (host_rdata[0] !== ref_mem[0][1]) begin
            errors++; $display("[TB] FAIL protect_unchanged: got %h expected %h", host_rdata[0], ref_mem[0][1]);
        end
        step();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp;
        do_reset();
        preload(8'h20, 32'hAAAA_0020);
        preload(8'h21, 32'hBBBB_0021);
        for (int r = 0; r < 3; r++) begin
            host_read_start(8'h20);
            disp_req = 1'b1; disp_rw = 1'b0; disp_addr = 8'h21;
            for (int c = 1; c <= 7; c++) begin
                step();
                idle_inputs();
                exp = {c <= 3, c == 3, c <= 6, c == 6};
                checks++;
                if ({host_busy[0], host_valid[0], disp_busy[0], disp_valid[0]} !== exp) begin
                    errors++; $display("[TB] FAIL rr_round%0d_c%0d: got hb/hv/db/dv %b expected %b", r, c,
                                       {host_busy[0], host_valid[0], disp_busy[0], disp_valid[0]}, exp);
                end
                if (c == 6) begin
                    checks++;
                    if ({host_rdata[0], disp_rdata[0]} !== {32'hAAAA_0020, 32'hBBBB_0021}) begin
                        errors++; $display("[TB] FAIL rr_data_round%0d: got %h %h expected aaaa0020 bbbb0021", r, host_rdata[0], disp_rdata[0]);
                    end
                end
            end
        end
    endtask

    task automatic test_priority();
        logic [3:0] exp;
        do_reset();
        host_read_start(8'h20);
        step();
        idle_inputs();
        step(); step(); step();
        host_read_start(8'h20);
        disp_req = 1'b1; disp_rw = 1'b0; disp_addr = 8'h21;
        for (int c = 1; c <= 7; c++) begin
            step();
            idle_inputs();
            exp = (c == 3) ? 4'b0110 : (c == 6) ? 4'b1001 : 4'b0000;
            checks++;
            if ({host_valid[0], disp_valid[0], host_valid[1], disp_valid[1]} !== exp) begin
                errors++; $display("[TB] FAIL priority_c%0d: got rr hv/dv fp hv/dv %b expected %b", c,
                                   {host_valid[0], disp_valid[0], host_valid[1], disp_valid[1]}, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        host_read_start(8'h20);
        step();
        idle_inputs();
        step();
        iRESET_SYNC = 1'b1;
        step();
        iRESET_SYNC = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== '0) begin
                errors++; $display("[TB] FAIL reset_mid_flush inst%0d: got %h expected 0", k, obs[k]);
            end
        end
        step();
        checks++;
        if (host_valid !== 2'b00) begin
            errors++; $display("[TB] FAIL reset_mid_novalid: got %b expected 00", host_valid);
        end
        host_read_start(8'h21);
        step();
        idle_inputs();
        step();
        step();
        checks++;
        if ({host_valid[0], host_rdata[0]} !== {1'b1, 32'hBBBB_0021}) begin
            errors++; $display("[TB] FAIL reset_mid_recover: got valid %b data %h expected 1 bbbb0021", host_valid[0], host_rdata[0]);
        end
        step();
    endtask

    // Transaction-level model: each port holds at most one request; the shared memory
    // serves one transaction at a time as idle -> access -> response, one cycle each.
    task automatic test_random();
        bit          pv [2][2];
        bit          prw [2][2];
        logic [7:0]  paddr [2][2];
        logic [31:0] pdata [2][2];
        logic [31:0] hold [2][2];
        int          cur [2];
        int          age [2];
        int          last [2];
        bit          oldpv [2];
        bit          e_req, e_rw, e_prot, rst;
        logic [1:0]  e_valid;
        logic [7:0]  e_addr;
        logic [31:0] e_data;
        logic [110:0] exp;
        int          c, w;

        do_reset();
        for (int a = 0; a < 256; a++) preload(a[7:0], $urandom);
        for (int k = 0; k < 2; k++) begin
            cur[k] = -1; age[k] = 0; last[k] = 1;
            for (int p = 0; p < 2; p++) begin
                pv[k][p] = 1'b0; prw[k][p] = 1'b0; paddr[k][p] = 8'h00;
                pdata[k][p] = 32'h0; hold[k][p] = 32'h0;
            end
        end

        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < 2; k++) begin
                e_req = 1'b0; e_rw = 1'b0; e_prot = 1'b0; e_addr = 8'h00; e_data = 32'h0; e_valid = 2'b00;
                if (cur[k] >= 0 && age[k] == 1) begin
                    c = cur[k];
                    e_prot = prw[k][c] && (paddr[k][c] < 8'h02);
                    e_req = !e_prot; e_rw = prw[k][c]; e_addr = paddr[k][c]; e_data = pdata[k][c];
                end
                if (cur[k] >= 0 && age[k] == 2) e_valid[cur[k]] = 1'b1;
                exp = {pv[k][0], e_valid[0], pv[k][1], e_valid[1], e_req, e_rw, e_prot,
                       e_addr, e_data, hold[k][0], hold[k][1]};
                checks++;
                if (obs[k] !== exp) begin
                    errors++;
                    $display("[TB] FAIL random inst%0d cycle %0d: got %h expected %h", k, n, obs[k], exp);
                end
            end

            rst = ($urandom_range(0, 199) == 0);
            iRESET_SYNC = rst;
            host_req = ($urandom_range(0, 9) < 4); host_rw = $urandom_range(0, 1);
            host_addr = $urandom_range(0, 7);      host_wdata = $urandom;
            disp_req = ($urandom_range(0, 9) < 4); disp_rw = $urandom_range(0, 1);
            disp_addr = $urandom_range(0, 7);      disp_wdata = $urandom;

            for (int k = 0; k < 2; k++) begin
                if (cur[k] >= 0 && age[k] == 1) begin
                    c = cur[k];
                    if (prw[k][c] && paddr[k][c] >= 8'h02) ref_mem[k][paddr[k][c]] = pdata[k][c];
                end
                if (rst) begin
                    cur[k] = -1; age[k] = 0; last[k] = 1;
                    for (int p = 0; p < 2; p++) begin
                        pv[k][p] = 1'b0; hold[k][p] = 32'h0;
                    end
                end else begin
                    oldpv[0] = pv[k][0]; oldpv[1] = pv[k][1];
                    if (cur[k] >= 0 && age[k] == 1) begin
                        c = cur[k];
                        hold[k][c] = prw[k][c] ? 32'h0 : ref_mem[k][paddr[k][c]];
                        age[k] = 2;
                    end else if (cur[k] >= 0 && age[k] == 2) begin
                        pv[k][cur[k]] = 1'b0; last[k] = cur[k]; cur[k] = -1; age[k] = 0;
                    end else if (oldpv[0] || oldpv[1]) begin
                        if (oldpv[0] && oldpv[1]) w = (k == 1) ? 0 : 1 - last[k];
                        else w = oldpv[0] ? 0 : 1;
                        cur[k] = w; age[k] = 1;
                    end
                    if (host_req && !oldpv[0]) begin
                        pv[k][0] = 1'b1; prw[k][0] = host_rw; paddr[k][0] = host_addr; pdata[k][0] = host_wdata;
                    end
                    if (disp_req && !oldpv[1]) begin
                        pv[k][1] = 1'b1; prw[k][1] = disp_rw; paddr[k][1] = disp_addr; pdata[k][1] = disp_wdata;
                    end
                end
            end
            step();
        end
        iRESET_SYNC = 1'b0;
        idle_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mem_load = 1'b0; mem_addr = 8'h00; mem_wdata = 32'h0;
        iRESET_SYNC = 1'b1;
        idle_inputs();
        $display("[TB] start");
        test_reset();
        test_host_read();
        test_host_write();
        test_protect();
        test_round_robin();
        test_priority();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
